ps2_key_event_fsm: RTL
======================

Name: ps2_key_event_fsm

Overview:
- Consumer stage placed directly downstream of the PS/2 receiver FIFO.
- Pops scan-code bytes using the receiver's ready/nextdata_n handshake.
- Decodes set-2 make, break (F0) and extended (E0) sequences into a single tracked held key, a press counter and one-cycle press/release strobes.
- Its outputs feed the ASCII converter and the seven-segment display path.

Parameters:
COUNT_W, 8, width of press counter press_cnt

Ports:
clk  in  1  system clock, all state updates on posedge
clrn  in  1  asynchronous active-low reset
ready  in  1  receiver FIFO non-empty; data valid while high
data  in  8  FIFO head byte
overflow  in  1  receiver FIFO overflow flag
nextdata_n  out  1  active-low pop strobe to receiver, one cycle wide
key_valid  out  1  a key is currently held
key_code  out  8  make code of held key, 0x00 when none held
key_ext  out  1  held key was E0-prefixed
press_cnt  out  COUNT_W  count of distinct new key presses, wraps
press_pulse  out  1  one-cycle strobe on a counted press
release_pulse  out  1  one-cycle strobe on release of the held key

Behaviour:
- Reset (clrn=0, async, any time) forces the following values; the reset takes effect immediately and aborts any in-progress prefix sequence:
  - nextdata_n=1
  - key_valid=0, key_code=0x00, key_ext=0
  - press_cnt=0
  - press_pulse=0, release_pulse=0
  - state=S_IDLE
- Consume rule:
  - A byte is consumed at a posedge where ready=1 and registered nextdata_n=1.
  - At that edge nextdata_n goes 0 for exactly one cycle, then returns to 1.
  - No consume is possible while nextdata_n=0, so the minimum spacing between consumes is 2 cycles.
  - The receiver pops at the edge where nextdata_n=0; ready/data for the next byte are valid afterwards.
- Latency: all decode outputs and pulses update at the consume edge, visible 1 cycle after the byte was presented. Pulses last exactly 1 cycle.
- FSM states: S_IDLE, S_EXT (E0 seen), S_BRK (F0 seen), S_EXT_BRK (E0 F0 seen). Transitions on a consumed byte b:
  - b=E0: go to S_EXT from any state (restarts the prefix).
  - b=F0: S_IDLE->S_BRK; S_EXT->S_EXT_BRK; S_BRK/S_EXT_BRK stay.
  - b in {00, AA, EE, FA, FE, FF}: control/error code, no output change, go to S_IDLE.
  - Other b in S_IDLE/S_EXT (make), with ext=(state==S_EXT):
    - If key_valid=1, key_code=b and key_ext=ext: typematic repeat, no change.
    - Otherwise: key_code=b, key_ext=ext, key_valid=1, press_cnt+=1 (all-ones wraps to 0), press_pulse=1.
    - Next state: S_IDLE.
  - Other b in S_BRK/S_EXT_BRK (break), with ext=(state==S_EXT_BRK):
    - If key_valid=1 and both code and ext match: key_valid=0, key_code=0x00, key_ext=0, release_pulse=1.
    - Otherwise ignored.
    - Next state: S_IDLE.
- New press while another key is held: the new key replaces the held one, the count increments, and no release_pulse is issued for the old key.
- overflow=1 sampled at any posedge: state forced to S_IDLE (the pending prefix is discarded) and held-key state is kept.
  - If overflow=1 coincides with a consume, the pop still happens (nextdata_n pulses) but the byte is discarded with no output change.
- ready=0: nextdata_n stays 1 and the FSM holds its state indefinitely.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> key_valid=1, key_code=0x1C, press_cnt=1, one press_pulse; then key_valid=0, key_code=0x00, one release_pulse. Exactly 3 nextdata_n low pulses, each 1 cycle and spaced at least 2 cycles apart.
- Typematic: 1C,1C,1C,1C -> press_cnt=1, single press_pulse, key_code=0x1C held throughout.
- Extended: E0, 75, E0, F0, 75 -> key_ext=1, key_code=0x75, press_cnt=1; release_pulse on the final byte. Then sequence 75, E0, F0, 75 -> release ignored (ext mismatch) and key_valid stays 1.
- Wrap and replace: 256 alternating presses of 1C/32 with no breaks -> press_cnt returns to 0x00 (COUNT_W=8); key_code=0x32 at end.
- Control and overflow: bytes FA, AA produce no output change. Byte F0 followed by overflow=1 for one cycle, then 1C -> treated as a make, press_pulse=1, key_code=0x1C.
- Async reset asserted mid-sequence right after E0: outputs clear immediately without waiting for clk. After release, byte 75 -> key_ext=0 and press_cnt=1.

Source files
------------

// File: rtl/ps2_key_event_fsm.sv
// PS/2 set-2 scan-code consumer: pops bytes from the receiver FIFO and tracks a
// single held key (make/break/E0 prefixes), a press counter and press/release strobes.
module ps2_key_event_fsm #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic [COUNT_W-1:0] press_cnt,
    output logic               press_pulse,
    output logic               release_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

    state_e             state_q, state_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic               key_valid_q, key_valid_d;
    logic [7:0]         key_code_q, key_code_d;
    logic               key_ext_q, key_ext_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               press_q, press_d;
    logic               rel_q, rel_d;

    logic consume, take, is_ctrl, is_prefix, ext;

    // A pop is only issued when the previous pop strobe has retired.
    assign consume   = ready & nextdata_n_q;
    assign take      = consume & ~overflow;
    assign is_ctrl   = (data == 8'h00) || (data == 8'hAA) || (data == 8'hEE) ||
                       (data == 8'hFA) || (data == 8'hFE) || (data == 8'hFF);
    assign is_prefix = (data == 8'hE0) || (data == 8'hF0);
    assign ext       = (state_q == S_EXT) || (state_q == S_EXT_BRK);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            nextdata_n_q <= 1'b1;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            rel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            rel_q        <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (overflow) begin
            state_d = S_IDLE;
        end else if (consume) begin
            if (data == 8'hE0) begin
                state_d = S_EXT;
            end else if (data == 8'hF0) begin
                case (state_q)
                    S_IDLE:  state_d = S_BRK;
                    S_EXT:   state_d = S_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        nextdata_n_d = ~consume;
        key_valid_d  = key_valid_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        cnt_d        = cnt_q;
        press_d      = 1'b0;
        rel_d        = 1'b0;
        if (take && !is_ctrl && !is_prefix) begin
            if (state_q == S_IDLE || state_q == S_EXT) begin
                // Same code and prefix while held is typematic repeat.
                if (!(key_valid_q && key_code_q == data && key_ext_q == ext)) begin
                    key_valid_d = 1'b1;
                    key_code_d  = data;
                    key_ext_d   = ext;
                    cnt_d       = cnt_q + COUNT_W'(1);
                    press_d     = 1'b1;
                end
            end else if (key_valid_q && key_code_q == data && key_ext_q == ext) begin
                key_valid_d = 1'b0;
                key_code_d  = 8'h00;
                key_ext_d   = 1'b0;
                rel_d       = 1'b1;
            end
        end
    end

    assign nextdata_n    = nextdata_n_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign press_cnt     = cnt_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule
